// File: rtl/meter_pwm_bank_if.sv
// meter_pwm_bank_if: value/calibration bus and meter outputs
// shared between the meter driver and whatever feeds it.
interface meter_pwm_bank_if #(
    parameter int CH = 3
);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;

    logic [CH*8-1:0] value_bcd;
    logic            value_valid;
    logic            snap;
    logic            cal_we;
    logic [CW-1:0]   cal_ch;
    logic [15:0]     cal_scale;
    logic [CH-1:0]   pwm;
    logic            busy;
    logic            bcd_err;

    modport master (
        output value_bcd,
        output value_valid,
        output snap,
        output cal_we,
        output cal_ch,
        output cal_scale,
        input  pwm,
        input  busy,
        input  bcd_err
    );

    modport slave (
        input  value_bcd,
        input  value_valid,
        input  snap,
        input  cal_we,
        input  cal_ch,
        input  cal_scale,
        output pwm,
        output busy,
        output bcd_err
    );
endinterface

// File: rtl/meter_pwm_bank.sv
// meter_pwm_bank: N-channel BCD-to-PWM moving-coil meter driver
// with runtime calibration and slew-limited needle motion.
module meter_pwm_bank #(
    parameter int CH        = 3,
    parameter int SYSCLKHZ  = 50_000_000,
    parameter int PWM_HZ    = 1_000,
    parameter int PERIOD    = SYSCLKHZ / PWM_HZ,
    parameter int DW        = $clog2(PERIOD + 1),
    parameter int DEF_SCALE = PERIOD / 99,
    parameter int SLEW_STEP = PERIOD / 100
) (
    input logic            clk,
    input logic            rst,
    meter_pwm_bank_if.slave bus
);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [DW-1:0] FULL  = DW'(PERIOD);
    localparam logic [DW-1:0] LAST  = DW'(PERIOD - 1);
    localparam logic [DW-1:0] SLEW  = DW'(SLEW_STEP);
    localparam logic [15:0]   SCL0  = 16'(DEF_SCALE);
    localparam logic [CW-1:0] CH_HI = CW'(CH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_COMMIT
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CW-1:0]   ch;
    logic [CH*8-1:0] bcd_q;
    logic            err_q;
    logic [15:0]     scale   [CH];
    logic [DW-1:0]   tgt_tmp [CH];
    logic [DW-1:0]   tgt     [CH];
    logic [DW-1:0]   cur     [CH];
    logic [DW-1:0]   cur_nx  [CH];
    logic [DW-1:0]   cnt;
    logic [CH-1:0]   pwm_q;

    logic            busy;
    logic            bcd_err;
    logic            accept;
    logic            last;
    logic            frame_edge;
    logic [7:0]      byte_sel;
    logic [3:0]      tens;
    logic [3:0]      ones;
    logic            dig_bad;
    logic [7:0]      bin;
    logic [22:0]     prod;
    logic [DW-1:0]   sat;

    assign bus.busy    = busy;
    assign bus.bcd_err = bcd_err;
    assign bus.pwm     = pwm_q;

    // One shared BCD->binary->scaled datapath, walked by ch.
    always_comb begin
        byte_sel = bcd_q[8*int'(ch) +: 8];
        tens     = byte_sel[7:4];
        ones     = byte_sel[3:0];
        dig_bad  = (tens > 4'd9) || (ones > 4'd9);
        bin      = {4'd0, tens} * 8'd10 + {4'd0, ones};
        prod     = 23'(bin) * 23'(scale[ch]);
        sat      = (prod > 23'(PERIOD)) ? FULL : DW'(prod);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        bcd_err  = 1'b0;
        accept   = 1'b0;
        last     = (ch == CH_HI);
        unique case (state)
            S_IDLE: begin
                if (bus.value_valid) begin
                    accept   = 1'b1;
                    state_nx = S_CONV;
                end
            end
            S_CONV: begin
                busy = 1'b1;
                if (last) begin
                    state_nx = S_COMMIT;
                end
            end
            S_COMMIT: begin
                busy     = 1'b1;
                bcd_err  = err_q;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch    <= '0;
            err_q <= 1'b0;
            bcd_q <= '0;
            for (int k = 0; k < CH; k++) begin
                tgt_tmp[k] <= '0;
                tgt[k]     <= '0;
            end
        end else begin
            if (accept) begin
                bcd_q <= bus.value_bcd;
                ch    <= '0;
                err_q <= 1'b0;
            end
            if (state == S_CONV) begin
                tgt_tmp[ch] <= sat;
                ch          <= ch + 1'b1;
                if (dig_bad) begin
                    err_q <= 1'b1;
                end
            end
            // All needles retarget together, or none do.
            if (state == S_COMMIT && !err_q) begin
                for (int k = 0; k < CH; k++) begin
                    tgt[k] <= tgt_tmp[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < CH; k++) begin
                scale[k] <= SCL0;
            end
        end else if (bus.cal_we && int'(bus.cal_ch) < CH) begin
            scale[bus.cal_ch] <= bus.cal_scale;
        end
    end

    always_comb begin
        for (int k = 0; k < CH; k++) begin
            cur_nx[k] = cur[k];
            if (bus.snap) begin
                cur_nx[k] = tgt[k];
            end else if (cur[k] < tgt[k]) begin
                cur_nx[k] = (tgt[k] - cur[k] > SLEW)
                          ? cur[k] + SLEW : tgt[k];
            end else if (cur[k] > tgt[k]) begin
                cur_nx[k] = (cur[k] - tgt[k] > SLEW)
                          ? cur[k] - SLEW : tgt[k];
            end
        end
    end

    assign frame_edge = (cnt == LAST);

    // cur loads on the edge entering cnt==0, so a frame has one duty.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            pwm_q <= '0;
            for (int k = 0; k < CH; k++) begin
                cur[k] <= '0;
            end
        end else begin
            cnt <= frame_edge ? '0 : cnt + 1'b1;
            for (int k = 0; k < CH; k++) begin
                pwm_q[k] <= (cnt < cur[k]);
                if (frame_edge) begin
                    cur[k] <= cur_nx[k];
                end
            end
        end
    end
endmodule

// File: tb/tb_meter_pwm_bank.sv
// tb_meter_pwm_bank: frame-level duty checks of meter_pwm_bank
// against a behavioural needle model.
module tb_meter_pwm_bank;
    localparam int CH = 3;
    localparam int P  = 100;
    localparam int SL = 1;
    localparam int DS = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    meter_pwm_bank_if #(.CH(CH)) bus ();

    meter_pwm_bank #(
        .CH(CH),
        .SYSCLKHZ(1000),
        .PWM_HZ(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int npass = 0;
    int nchk  = 0;
    int mcnt  = 0;
    int m_tgt   [CH];
    int m_cur   [CH];
    int m_scale [CH];

    // Reference: frame position and needle positions.
    always @(posedge clk) begin
        if (rst) begin
            mcnt = 0;
            for (int k = 0; k < CH; k++) m_cur[k] = 0;
        end else begin
            if (mcnt == P - 1) begin
                for (int k = 0; k < CH; k++) begin
                    if (bus.snap) m_cur[k] = m_tgt[k];
                    else if (m_cur[k] < m_tgt[k])
                        m_cur[k] = (m_tgt[k] - m_cur[k] > SL)
                                 ? m_cur[k] + SL : m_tgt[k];
                    else if (m_cur[k] > m_tgt[k])
                        m_cur[k] = (m_cur[k] - m_tgt[k] > SL)
                                 ? m_cur[k] - SL : m_tgt[k];
                end
            end
            mcnt = (mcnt == P - 1) ? 0 : mcnt + 1;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic sync(input int m);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mcnt != m && n < 3 * P);
        if (mcnt != m) begin
            nchk++;
            $error("FAIL sync: observed %0d expected %0d", mcnt, m);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.value_valid = 1'b0;
        bus.cal_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < CH; k++) begin
            m_tgt[k]   = 0;
            m_scale[k] = DS;
        end
    endtask

    task automatic cal(input int c, input int s);
        @(negedge clk);
        bus.cal_we    = 1'b1;
        bus.cal_ch    = 2'(c);
        bus.cal_scale = 16'(s);
        @(negedge clk);
        bus.cal_we = 1'b0;
        if (c < CH) m_scale[c] = s;
    endtask

    task automatic model_update(input logic [CH*8-1:0] v,
                                output bit err);
        int t [CH];
        int tn, on, p;
        err = 1'b0;
        for (int k = 0; k < CH; k++) begin
            tn = int'(v[8*k+4 +: 4]);
            on = int'(v[8*k +: 4]);
            if (tn > 9 || on > 9) err = 1'b1;
            p = (tn * 10 + on) * m_scale[k];
            t[k] = (p > P) ? P : p;
        end
        if (!err) for (int k = 0; k < CH; k++) m_tgt[k] = t[k];
    endtask

    task automatic send(input logic [CH*8-1:0] v, input bit hammer,
                        input string tag);
        int nb, ne;
        bit err;
        logic [63:0] junk;
        nb = 0;
        ne = 0;
        sync(2);
        bus.value_bcd   = v;
        bus.value_valid = 1'b1;
        for (int i = 0; i <= CH + 3; i++) begin
            @(negedge clk);
            if (i == 0) begin
                junk = {$urandom, $urandom};
                bus.value_bcd = junk[CH*8-1:0];
            end
            if (!hammer || i == CH + 1) bus.value_valid = 1'b0;
            if (bus.busy) nb++;
            if (bus.bcd_err) ne++;
        end
        model_update(v, err);
        chk({tag, " busy_cycles"}, nb, CH + 1);
        chk({tag, " bcd_err_pulses"}, ne, err ? 1 : 0);
    endtask

    task automatic frame_chk(input string tag);
        int hi  [CH];
        int exp [CH];
        sync(1);
        for (int k = 0; k < CH; k++) begin
            exp[k] = m_cur[k];
            hi[k]  = 0;
        end
        for (int i = 0; i < P; i++) begin
            if (i > 0) @(negedge clk);
            for (int k = 0; k < CH; k++) if (bus.pwm[k]) hi[k]++;
        end
        for (int k = 0; k < CH; k++)
            chk($sformatf("%s duty ch%0d", tag, k), hi[k], exp[k]);
    endtask

    function automatic logic [CH*8-1:0] rand_bcd();
        logic [CH*8-1:0] v;
        for (int k = 0; k < CH; k++) begin
            if ($urandom_range(0, 7) == 0)
                v[8*k +: 8] = 8'($urandom_range(0, 255));
            else
                v[8*k +: 8] = {4'($urandom_range(0, 9)),
                               4'($urandom_range(0, 9))};
        end
        return v;
    endfunction

    initial begin
        bus.value_bcd   = '0;
        bus.value_valid = 1'b0;
        bus.snap        = 1'b1;
        bus.cal_we      = 1'b0;
        bus.cal_ch      = '0;
        bus.cal_scale   = '0;

        do_reset();
        chk("reset busy", int'(bus.busy), 0);
        chk("reset bcd_err", int'(bus.bcd_err), 0);
        chk("reset pwm", int'(bus.pwm), 0);
        for (int f = 0; f < 3; f++) frame_chk($sformatf("idle f%0d", f));

        send(24'h12_34_59, 1'b0, "time");
        frame_chk("time");
        chk("time ch0 duty model", m_cur[0], 59);

        cal(1, 3);
        cal(3, 77);
        send(24'h00_40_00, 1'b0, "sat");
        frame_chk("sat");

        send(24'h00_00_59, 1'b0, "pre_slew");
        frame_chk("pre_slew");
        bus.snap = 1'b0;
        send(24'h00_00_00, 1'b0, "slew");
        for (int f = 0; f < 60; f++) frame_chk($sformatf("slew f%0d", f));
        chk("slew end ch0", m_cur[0], 0);

        bus.snap = 1'b1;
        send(24'h21_23_45, 1'b0, "good");
        frame_chk("good");
        send(24'h12_34_5A, 1'b0, "bad");
        frame_chk("bad");

        send(24'h09_11_27, 1'b1, "hammer");
        frame_chk("hammer");

        for (int r = 0; r < 10; r++) begin
            cal($urandom_range(0, 3), $urandom_range(0, 4));
            bus.snap = 1'($urandom_range(0, 1));
            send(rand_bcd(), 1'($urandom_range(0, 1)),
                 $sformatf("rnd%0d", r));
            frame_chk($sformatf("rnd%0d a", r));
            frame_chk($sformatf("rnd%0d b", r));
        end

        bus.snap = 1'b1;
        send(24'h33_22_11, 1'b0, "pre_rst");
        frame_chk("pre_rst");
        sync(2);
        bus.value_bcd   = 24'h00_00_5A;
        bus.value_valid = 1'b1;
        @(negedge clk);
        bus.value_valid = 1'b0;
        chk("midconv busy", int'(bus.busy), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < CH; k++) begin
            m_tgt[k]   = 0;
            m_scale[k] = DS;
        end
        chk("rst busy", int'(bus.busy), 0);
        begin
            int ne;
            ne = 0;
            for (int i = 0; i < 2 * CH + 4; i++) begin
                if (bus.bcd_err) ne++;
                @(negedge clk);
            end
            chk("rst no bcd_err", ne, 0);
        end
        frame_chk("after rst");
        send(24'h01_02_03, 1'b0, "post_rst");
        frame_chk("post_rst");

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule

// File: doc/meter_pwm_bank.md
# meter_pwm_bank

Parametrised N-channel moving-coil meter driver for the ammeter clock: it replaces the fixed three-output hour/minute/second PWM stage. The block takes a packed vector of two-digit BCD values, such as the RTC time fields read over I2C. It validates and converts each value to binary and scales it with a per-channel runtime calibration factor. Each needle is slewed toward its new position, and one glitch-free PWM output per channel is driven. Calibration is written at run time from the UART/key control path, so meters can be trimmed without a rebuild.

## Interface
- CH, 3: number of meter channels; index 0 is seconds, 1 minutes, 2 hours, then user channels.
- SYSCLKHZ, 50_000_000: system clock frequency in Hz.
- PWM_HZ, 1_000: PWM frame rate. PERIOD = SYSCLKHZ/PWM_HZ, 50_000 at defaults.
- DW, $clog2(PERIOD+1): width of the duty and frame counter.
- DEF_SCALE, PERIOD/99: reset value of every channel's calibration scale.
- SLEW_STEP, PERIOD/100: maximum duty change per PWM frame in slew mode.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- value_bcd  in  CH*8  packed BCD values; channel k is [8k+7:8k], with tens digit high.
- value_valid  in  1  one-cycle strobe; value_bcd is sampled when the strobe is accepted.
- snap  in  1  1 = jump straight to target at the next frame, 0 = slew.
- cal_we  in  1  calibration write strobe.
- cal_ch  in  $clog2(CH) (minimum 1)  calibration channel index.
- cal_scale  in  16  new scale value for cal_ch.
- pwm  out  CH  meter PWM outputs.
- busy  out  1  high while a conversion is in progress.
- bcd_err  out  1  one-cycle pulse when an update is rejected.

## Operation
- State machine: IDLE -> CONV -> COMMIT -> IDLE.
  - IDLE: value_valid is accepted here only. value_bcd is latched, and the machine goes to CONV with ch=0 and busy=1.
  - CONV: handles one channel per cycle using one shared multiplier.
    - bin = tens*10 + ones.
    - prod = bin * scale[ch], computed at 23 bits.
    - tgt_tmp[ch] = min(prod, PERIOD).
    - Any digit above 9 sets an error flag.
    - After ch = CH-1 the machine goes to COMMIT.
  - COMMIT: if there is no error, every tgt_tmp is copied to tgt at once. If there is an error, tgt is left unchanged and bcd_err pulses. busy drops when the machine returns to IDLE.
- value_valid arriving while busy=1 is ignored; it is not queued.
- cal_we may arrive in any state and writes scale[cal_ch] on the next edge.
  - cal_ch >= CH: the write is ignored.
  - A write during CONV affects only channels not yet processed.
  - A new scale does not move a needle until the next accepted value update.
- Frame counter: runs 0..PERIOD-1 and wraps. Frame start is cnt==0.
- Duty update per channel, only at frame start, so no mid-frame glitches:
  - snap=1: cur = tgt.
  - snap=0, cur<tgt: cur = min(cur+SLEW_STEP, tgt).
  - snap=0, cur>tgt: cur = max(cur-SLEW_STEP, tgt).
  - Wrap-around (59->00, the clock rolling over) is a normal downward slew; no special sweep.
- Output: pwm[k] = (cnt < cur[k]), registered.
  - cur=0 holds the output low for the whole frame.
  - cur=PERIOD holds it high for the whole frame.

## Timing
- Reset values:
  - State IDLE, cnt=0.
  - Every cur and tgt = 0; every scale = DEF_SCALE.
  - pwm=0, busy=0, bcd_err=0.
- A reset in the middle of a conversion abandons it. tgt stays 0 and no bcd_err is issued.
- busy rises the cycle after value_valid is accepted and stays high for CH+1 cycles (CONV×CH plus COMMIT).
- tgt is visible the cycle after COMMIT.
- cur moves at the first frame start after that, so worst-case latency to a PWM change is CH+2+PERIOD cycles.
- Full-scale slew takes ceil(PERIOD/SLEW_STEP) frames: 100 frames, 100 ms at defaults.
- pwm lags cnt and cur by one register stage.
- A simultaneous value_valid and COMMIT is ignored, because busy is still high.

## Test plan
Bench uses SYSCLKHZ=1000, PWM_HZ=10, so PERIOD=100, DEF_SCALE=1, SLEW_STEP=1, with CH=3.
- Reset, no stimulus -> pwm=000, busy=0; all outputs stay low for 3 frames.
- value_bcd=0x12_34_59, snap=1 -> busy high for exactly 4 cycles. From the next frame, duty per frame is ch0=59, ch1=34, ch2=12 high cycles.
- cal_we with ch=1, scale=3, then value 0x00_40_00 with snap=1 -> ch1 duty is 100 (120 saturated), i.e. high for the whole frame; ch0=ch2=0, low for the whole frame.
- Slew: cur=59, then ch0 value 0x00, snap=0 -> ch0 duty steps 58, 57, … by one per frame and reaches 0 after 59 frames.
- ch0 byte 0x5A -> bcd_err pulses once. tgt is unchanged on all channels, including those with valid digits.
- value_valid during busy is ignored. A rst pulse during CONV -> IDLE, busy=0, all duties 0, no bcd_err.
